// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction-fetch stage: owns the program counter, chooses the next PC from
// branch / jump / stall requests, presents the PC to a combinational
// instruction memory, and tells the IF/ID register when to squash.
// A misaligned redirect parks the unit in FAULT until reset.
//
// Ports
//   Clk              rising-edge clock
//   Rst              asynchronous active-low reset
//   Stall            hold the PC (hazard unit)
//   Branch_taken     EX-stage branch resolved taken (highest priority)
//   Branch_target    branch destination
//   Jump             ID-stage jump decoded
//   Jump_target      jump destination
//   Imem_rdata       instruction word at Imem_addr
//   Imem_addr        current PC
//   PCAdder_out      PC + 4 (wraps modulo 2^32)
//   Instruction_out  Imem_rdata passthrough
//   IFID_flush       squash the instruction latched by IF/ID
//   Fetch_fault      misaligned redirect seen, sticky until reset
//   Fetch_count      delivered-instruction counter (saturating)
//   Stall_count      stall-cycle counter (saturating)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_target,
  input  logic        Jump,
  input  logic [31:0] Jump_target,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] Imem_addr,
  output logic [31:0] PCAdder_out,
  output logic [31:0] Instruction_out,
  output logic        IFID_flush,
  output logic        Fetch_fault,
  output logic [15:0] Fetch_count,
  output logic [15:0] Stall_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        fault_q;

  logic        redirect;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_plus4;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign pc_plus4     = pc_q + 32'd4;
  // Branch resolves later in the pipe than a jump, so it wins.
  assign redirect     = Branch_taken | Jump;
  assign redirect_tgt = Branch_taken ? Branch_target : Jump_target;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    IFID_flush  = 1'b0;
    unique case (state_q)
      BOOT: begin
        IFID_flush = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (redirect) begin
          // Any redirect squashes the wrong-path fetch and overrides Stall.
          IFID_flush = 1'b1;
          if (redirect_tgt[1:0] != 2'b00) begin
            state_d = FAULT;
          end else begin
            pc_d = redirect_tgt;
          end
        end else if (Stall) begin
          stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
          pc_d        = pc_plus4;
          fetch_cnt_d = sat_inc(fetch_cnt_q);
        end
      end
      FAULT: begin
        IFID_flush = 1'b1;
      end
      default: begin
        IFID_flush = 1'b1;
        state_d    = FAULT;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      fetch_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      // Tracks the FAULT state one-for-one, but comes straight from a flop.
      fault_q     <= (state_d == FAULT);
    end
  end

  assign Imem_addr       = pc_q;
  assign PCAdder_out     = pc_plus4;
  assign Instruction_out = Imem_rdata;
  assign Fetch_fault     = fault_q;
  assign Fetch_count     = fetch_cnt_q;
  assign Stall_count     = stall_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int S_BOOT  = 0;
  localparam int S_RUN   = 1;
  localparam int S_FAULT = 2;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Stall;
  logic        Branch_taken;
  logic [31:0] Branch_target;
  logic        Jump;
  logic [31:0] Jump_target;
  logic [31:0] Imem_rdata;
  logic [31:0] Imem_addr;
  logic [31:0] PCAdder_out;
  logic [31:0] Instruction_out;
  logic        IFID_flush;
  logic        Fetch_fault;
  logic [15:0] Fetch_count;
  logic [15:0] Stall_count;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall),
    .Branch_taken(Branch_taken), .Branch_target(Branch_target),
    .Jump(Jump), .Jump_target(Jump_target),
    .Imem_rdata(Imem_rdata), .Imem_addr(Imem_addr),
    .PCAdder_out(PCAdder_out), .Instruction_out(Instruction_out),
    .IFID_flush(IFID_flush), .Fetch_fault(Fetch_fault),
    .Fetch_count(Fetch_count), .Stall_count(Stall_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] fc;
    logic [15:0] sc;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad   = 0;

  // Reference model
  int          m_state;
  logic [31:0] m_pc;
  logic [15:0] m_fc;
  logic [15:0] m_sc;

  function automatic logic [15:0] ref_sat(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  function automatic logic ref_flush();
    return (m_state == S_BOOT) || (m_state == S_FAULT) ||
           ((m_state == S_RUN) && (Branch_taken || Jump));
  endfunction

  task automatic model_reset();
    m_state = S_BOOT;
    m_pc    = RST_PC;
    m_fc    = 16'd0;
    m_sc    = 16'd0;
    sb.delete();
  endtask

  task automatic idle_inputs();
    Stall = 1'b0; Branch_taken = 1'b0; Jump = 1'b0;
    Branch_target = 32'h0; Jump_target = 32'h0;
  endtask

  // Apply current inputs to the model, queue the post-edge expectation,
  // then cross exactly one rising edge and land 1 time unit after it.
  task automatic advance();
    logic [31:0] tgt;
    exp_t x;
    case (m_state)
      S_BOOT: m_state = S_RUN;
      S_RUN: begin
        if (Branch_taken || Jump) begin
          tgt = Branch_taken ? Branch_target : Jump_target;
          if (tgt[1:0] != 2'b00) m_state = S_FAULT;
          else m_pc = tgt;
        end else if (Stall) begin
          m_sc = ref_sat(m_sc);
        end else begin
          m_pc = m_pc + 32'd4;
          m_fc = ref_sat(m_fc);
        end
      end
      default: ;
    endcase
    x.pc = m_pc; x.fc = m_fc; x.sc = m_sc; x.fault = (m_state == S_FAULT);
    sb.push_back(x);
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    Imem_rdata = 32'h1234_5678;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    model_reset();
    #1;
    total++; if (Imem_addr !== RST_PC) begin bad++; $display("FAIL reset_addr got=%h want=%h", Imem_addr, RST_PC); end
    total++; if (PCAdder_out !== RST_PC + 32'd4) begin bad++; $display("FAIL reset_adder got=%h want=%h", PCAdder_out, RST_PC + 32'd4); end
    total++; if (IFID_flush !== 1'b1) begin bad++; $display("FAIL reset_flush got=%b want=1", IFID_flush); end
    total++; if (Fetch_count !== 16'd0 || Stall_count !== 16'd0) begin bad++; $display("FAIL reset_counts got=%h/%h want=0/0", Fetch_count, Stall_count); end
    total++; if (Fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", Fetch_fault); end
    @(posedge Clk); #1;
    total++; if (Imem_addr !== RST_PC || IFID_flush !== 1'b1) begin bad++; $display("FAIL reset_held_edge got=%h/%b want=%h/1", Imem_addr, IFID_flush, RST_PC); end
    Rst = 1'b1;
    #2;
  endtask

  task automatic test_boot_run();
    logic [31:0] seq [0:3];
    seq[0] = 32'h0; seq[1] = 32'h0; seq[2] = 32'h4; seq[3] = 32'h8;
    for (int i = 0; i < 4; i++) begin
      Imem_rdata = $urandom;
      #2;
      total++; if (Imem_addr !== seq[i]) begin bad++; $display("FAIL boot_addr[%0d] got=%h want=%h", i, Imem_addr, seq[i]); end
      total++; if (IFID_flush !== (i == 0)) begin bad++; $display("FAIL boot_flush[%0d] got=%b want=%b", i, IFID_flush, (i == 0)); end
      total++; if (Instruction_out !== Imem_rdata) begin bad++; $display("FAIL instr_pass[%0d] got=%h want=%h", i, Instruction_out, Imem_rdata); end
      advance();
      e = sb.pop_front();
      total++; if (Imem_addr !== e.pc || Fetch_count !== e.fc) begin bad++; $display("FAIL boot_step[%0d] got=%h/%h want=%h/%h", i, Imem_addr, Fetch_count, e.pc, e.fc); end
    end
    total++; if (Imem_addr !== 32'hC || Fetch_count !== 16'd3) begin bad++; $display("FAIL boot_final got=%h/%0d want=c/3", Imem_addr, Fetch_count); end
  endtask

  task automatic test_stall();
    idle_inputs();
    advance();
    e = sb.pop_front();
    total++; if (Imem_addr !== 32'h10) begin bad++; $display("FAIL stall_start got=%h want=10", Imem_addr); end
    Stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      total++; if (IFID_flush !== 1'b0) begin bad++; $display("FAIL stall_flush[%0d] got=%b want=0", i, IFID_flush); end
      advance();
      e = sb.pop_front();
      total++; if (Imem_addr !== e.pc || Stall_count !== e.sc) begin bad++; $display("FAIL stall_hold[%0d] got=%h/%0d want=%h/%0d", i, Imem_addr, Stall_count, e.pc, e.sc); end
    end
    Stall = 1'b0;
    advance();
    e = sb.pop_front();
    total++; if (Imem_addr !== 32'h14 || Stall_count !== 16'd2 || Imem_addr !== e.pc) begin bad++; $display("FAIL stall_release got=%h/%0d want=14/2", Imem_addr, Stall_count); end
  endtask

  task automatic test_priority();
    Jump = 1'b1; Jump_target = 32'h20;
    #2;
    total++; if (IFID_flush !== 1'b1) begin bad++; $display("FAIL jump_flush got=%b want=1", IFID_flush); end
    advance();
    e = sb.pop_front();
    total++; if (Imem_addr !== 32'h20 || Imem_addr !== e.pc) begin bad++; $display("FAIL jump_pc got=%h want=20", Imem_addr); end
    Branch_taken = 1'b1; Branch_target = 32'h100;
    Jump = 1'b1; Jump_target = 32'h200; Stall = 1'b1;
    #2;
    total++; if (IFID_flush !== 1'b1) begin bad++; $display("FAIL prio_flush got=%b want=1", IFID_flush); end
    advance();
    e = sb.pop_front();
    total++; if (Imem_addr !== 32'h100 || Imem_addr !== e.pc) begin bad++; $display("FAIL prio_pc got=%h want=100", Imem_addr); end
    total++; if (Stall_count !== 16'd2 || Stall_count !== e.sc) begin bad++; $display("FAIL prio_stallcnt got=%0d want=2", Stall_count); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    Jump = 1'b1; Jump_target = 32'hFFFF_FFFC;
    advance();
    e = sb.pop_front();
    Jump = 1'b0;
    #2;
    total++; if (Imem_addr !== e.pc || PCAdder_out !== 32'h0) begin bad++; $display("FAIL wrap_pre got=%h/%h want=fffffffc/0", Imem_addr, PCAdder_out); end
    advance();
    e = sb.pop_front();
    total++; if (Imem_addr !== 32'h0 || Imem_addr !== e.pc || PCAdder_out !== 32'h4) begin bad++; $display("FAIL wrap_post got=%h/%h want=0/4", Imem_addr, PCAdder_out); end
  endtask

  task automatic test_reset_mid_redirect();
    Jump = 1'b1; Jump_target = 32'h80;
    #2;
    Rst = 1'b0;
    model_reset();
    #1;
    total++; if (Imem_addr !== RST_PC || Fetch_count !== 16'd0) begin bad++; $display("FAIL midrst_now got=%h/%0d want=%h/0", Imem_addr, Fetch_count, RST_PC); end
    @(posedge Clk); #1;
    total++; if (Imem_addr !== RST_PC || IFID_flush !== 1'b1) begin bad++; $display("FAIL midrst_edge got=%h/%b want=%h/1", Imem_addr, IFID_flush, RST_PC); end
    Rst = 1'b1;
    #2;
    advance();
    e = sb.pop_front();
    total++; if (Imem_addr !== RST_PC || Imem_addr !== e.pc || IFID_flush !== 1'b1) begin bad++; $display("FAIL midrst_boot got=%h/%b want=%h/1", Imem_addr, IFID_flush, RST_PC); end
    idle_inputs();
  endtask

  task automatic test_fault();
    Jump = 1'b1; Jump_target = 32'h40;
    advance();
    e = sb.pop_front();
    total++; if (Imem_addr !== 32'h40 || Imem_addr !== e.pc) begin bad++; $display("FAIL fault_setup got=%h want=40", Imem_addr); end
    Jump_target = 32'h102;
    #2;
    total++; if (IFID_flush !== 1'b1) begin bad++; $display("FAIL fault_flush_now got=%b want=1", IFID_flush); end
    advance();
    e = sb.pop_front();
    total++; if (Imem_addr !== 32'h40 || Fetch_fault !== 1'b1 || Fetch_fault !== e.fault) begin bad++; $display("FAIL fault_enter got=%h/%b want=40/1", Imem_addr, Fetch_fault); end
    for (int i = 0; i < 3; i++) begin
      Branch_taken = 1'b1; Branch_target = 32'h200 + 32'(i * 4);
      Jump = i[0]; Stall = i[1];
      Imem_rdata = $urandom;
      #2;
      total++; if (IFID_flush !== 1'b1 || Instruction_out !== Imem_rdata) begin bad++; $display("FAIL fault_flush[%0d] got=%b/%h want=1/%h", i, IFID_flush, Instruction_out, Imem_rdata); end
      advance();
      e = sb.pop_front();
      total++; if (Imem_addr !== e.pc || Fetch_fault !== e.fault || Stall_count !== e.sc || Fetch_count !== e.fc) begin bad++; $display("FAIL fault_ignore[%0d] got=%h/%b want=%h/%b", i, Imem_addr, Fetch_fault, e.pc, e.fault); end
    end
    idle_inputs();
    Rst = 1'b0;
    model_reset();
    #1;
    total++; if (Imem_addr !== RST_PC || Fetch_fault !== 1'b0) begin bad++; $display("FAIL fault_reset got=%h/%b want=%h/0", Imem_addr, Fetch_fault, RST_PC); end
    Rst = 1'b1;
    #1;
  endtask

  task automatic test_saturate();
    int errs = 0;
    for (int i = 0; i < 65540; i++) begin
      advance();
      e = sb.pop_front();
      if (Fetch_count !== e.fc || Imem_addr !== e.pc) begin
        errs++;
        if (errs <= 4) $display("FAIL sat_step[%0d] got=%h/%h want=%h/%h", i, Fetch_count, Imem_addr, e.fc, e.pc);
      end
    end
    total++; if (errs != 0) bad++;
    total++; if (Fetch_count !== 16'hFFFF) begin bad++; $display("FAIL sat_value got=%h want=ffff", Fetch_count); end
    advance();
    e = sb.pop_front();
    total++; if (Fetch_count !== 16'hFFFF || Fetch_count !== e.fc) begin bad++; $display("FAIL sat_hold got=%h want=ffff", Fetch_count); end
    #2;
    Rst = 1'b0;
    model_reset();
    #1;
    total++; if (Fetch_count !== 16'd0 || Stall_count !== 16'd0) begin bad++; $display("FAIL sat_clear got=%h/%h want=0/0", Fetch_count, Stall_count); end
    Rst = 1'b1;
  endtask

  initial begin
    idle_inputs();
    Imem_rdata = 32'h0;
    Rst = 1'b1;
    model_reset();
    test_reset();
    test_boot_run();
    test_stall();
    test_priority();
    test_wrap();
    test_reset_mid_redirect();
    test_fault();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
